// File: rtl/onchip_rom_pkg.sv
// Shared types and constants for the on-chip ROM boot loader.
package onchip_rom_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  // Every write covers all four byte lanes
  localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage : onchip_rom_pkg

// File: rtl/onchip_rom_word_packer.sv
// Assembles a little-endian 32-bit word from a stream of bytes.
module onchip_rom_word_packer
  import onchip_rom_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_byte_c
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  // Shift new bytes in at the top so the first byte ends up in [7:0]
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (push_i) begin
      word_d = {byte_i, word_q[WORD_W-1:BYTE_W]};
      idx_d  = idx_q + 2'd1;
    end
  end

  // Shift register and byte index storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o      = word_q;
  assign last_byte_c = push_i && !clear_i && (idx_q == 2'd3);

endmodule : onchip_rom_word_packer

// File: rtl/onchip_rom_loader.sv
// Streams a byte-wide boot image into an on-chip word memory.
module onchip_rom_loader
  import onchip_rom_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic              m_debugaccess,
  output logic              m_clken,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       checksum_q, checksum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic busy_q, busy_d;
  logic in_ready_q, in_ready_d;
  logic wr_q, wr_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic        start_ok_c;
  logic        xfer_c;
  logic        timeout_c;
  logic        last_word_c;
  logic        pack_clear_c;
  logic        pack_last_c;
  logic [31:0] pack_word;

  // Qualify requests, byte handshakes and end-of-load conditions
  assign start_ok_c   = start && (word_count != '0) && (word_count <= MAX_WORDS);
  assign xfer_c       = in_valid && in_ready_q;
  assign timeout_c    = (state_q == COLLECT) && !xfer_c && (idle_q == IDLE_LAST);
  assign last_word_c  = (words_q + CNT_W'(1)) == count_q;
  assign pack_clear_c = ((state_q == IDLE) && start_ok_c) || timeout_c;

  onchip_rom_word_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (pack_clear_c),
    .push_i      (xfer_c),
    .byte_i      (in_data),
    .word_o      (pack_word),
    .last_byte_c (pack_last_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok_c) state_d = COLLECT;
      end
      COLLECT: begin
        if (timeout_c)        state_d = IDLE;
        else if (pack_last_c) state_d = WRITE;
      end
      WRITE: begin
        if (last_word_c) state_d = FINISH;
        else             state_d = COLLECT;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath updates and next values of the registered outputs
  always_comb begin
    count_d    = count_q;
    words_d    = words_q;
    addr_d     = addr_q;
    checksum_d = checksum_q;
    idle_d     = idle_q;
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == COLLECT);
    wr_d       = (state_d == WRITE);
    done_d     = (state_d == FINISH);
    error_d    = ((state_q == IDLE) && start && !start_ok_c) || timeout_c;
    case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          count_d    = word_count;
          words_d    = '0;
          addr_d     = '0;
          checksum_d = '0;
          idle_d     = '0;
        end
      end
      COLLECT: begin
        if (xfer_c || timeout_c) idle_d = '0;
        else                     idle_d = idle_q + IDLE_W'(1);
      end
      WRITE: begin
        checksum_d = checksum_q + pack_word;
        words_d    = words_q + CNT_W'(1);
        // Hold the final address so a full-depth load never wraps
        if (!last_word_c) addr_d = addr_q + ADDR_W'(1);
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      checksum_q <= '0;
      idle_q     <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      checksum_q <= checksum_d;
      idle_q     <= idle_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign m_address     = addr_q;
  assign m_writedata   = pack_word;
  assign m_byteenable  = BYTEEN_ALL;
  assign m_chipselect  = wr_q;
  assign m_write       = wr_q;
  assign m_debugaccess = wr_q;
  assign m_clken       = 1'b1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign checksum      = checksum_q;

endmodule : onchip_rom_loader

// File: tb/tb_onchip_rom_loader.sv
// Directed bench for onchip_rom_loader with a write scoreboard.
module tb_onchip_rom_loader;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned TIMEOUT = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] m_address;
  logic [31:0]       m_writedata;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic              m_debugaccess;
  logic              m_clken;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       checksum;

  int  pass_cnt = 0;
  int  tot_cnt  = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;
  wr_t sb_q[$];

  always #5 clk = ~clk;

  onchip_rom_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .word_count    (word_count),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_debugaccess (m_debugaccess),
    .m_clken       (m_clken),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .checksum      (checksum)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt = tot_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: pops expected writes and counts status pulses on the falling edge
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (done === 1'b1)  done_cnt = done_cnt + 1;
      if (error === 1'b1) err_cnt  = err_cnt + 1;
      if (m_write === 1'b1) begin
        wr_cnt = wr_cnt + 1;
        if (sb_q.size() == 0) begin
          check("wr_unexpected", 64'(m_write), 64'd0);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          check("wr_addr", 64'(m_address), 64'(e.addr));
          check("wr_data", 64'(m_writedata), 64'(e.data));
          check("wr_side", 64'({m_chipselect, m_debugaccess, m_byteenable, m_clken, in_ready}),
                64'({1'b1, 1'b1, 4'hF, 1'b1, 1'b0}));
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after start is sampled
  task automatic do_start(input int n);
    start      = 1'b1;
    word_count = (ADDR_W + 1)'(n);
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Offer one byte and return once it has been accepted
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("byte_accept_wait", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int w0, d0, e0, n;
    wr_t   e;
    logic [7:0] b;

    reset_n    = 1'b0;
    start      = 1'b0;
    word_count = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    #3;
    check("reset_outputs",
          64'({in_ready, m_address, m_writedata, m_chipselect, m_write, m_debugaccess,
               busy, done, error, checksum}), 64'd0);
    check("reset_constants", 64'({m_byteenable, m_clken}), 64'({4'hF, 1'b1}));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Two-word back-to-back load
    e.addr = 9'd0; e.data = 32'h04030201; sb_q.push_back(e);
    e.addr = 9'd1; e.data = 32'h08070605; sb_q.push_back(e);
    w0 = wr_cnt; d0 = done_cnt;
    do_start(2);
    check("busy_after_start", 64'(busy), 64'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_idle("two_word_idle", 20);
    check("two_word_writes", 64'(wr_cnt - w0), 64'd2);
    check("two_word_checksum", 64'(checksum), 64'h0C0A0806);
    check("two_word_done", 64'(done_cnt - d0), 64'd1);
    check("two_word_sb_empty", 64'(sb_q.size()), 64'd0);

    // Zero-length request is rejected
    w0 = wr_cnt;
    do_start(0);
    check("zero_error_pulse", 64'(error), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zero_error_clears", 64'(error), 64'd0);
    check("zero_no_write", 64'(wr_cnt - w0), 64'd0);

    // Oversize request is rejected
    do_start(513);
    check("oversize_error", 64'({error, busy}), 64'({1'b1, 1'b0}));
    @(negedge clk);

    // Full-depth load of 0xFF bytes
    for (int i = 0; i < 512; i++) begin
      e.addr = ADDR_W'(i); e.data = 32'hFFFFFFFF; sb_q.push_back(e);
    end
    w0 = wr_cnt; d0 = done_cnt;
    do_start(512);
    for (int i = 0; i < 2048; i++) send_byte(8'hFF);
    wait_idle("full_idle", 20);
    check("full_writes", 64'(wr_cnt - w0), 64'd512);
    check("full_last_addr", 64'(m_address), 64'd511);
    check("full_checksum", 64'(checksum), 64'hFFFFFE00);
    check("full_done", 64'(done_cnt - d0), 64'd1);
    check("full_sb_empty", 64'(sb_q.size()), 64'd0);

    // Stall mid-word until the idle timeout fires
    w0 = wr_cnt;
    do_start(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    n = 0;
    while (error !== 1'b1 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 64'(n), 64'(TIMEOUT));
    check("timeout_state", 64'({error, busy, in_ready}), 64'({1'b1, 1'b0, 1'b0}));
    check("timeout_no_write", 64'(wr_cnt - w0), 64'd0);
    @(negedge clk);
    check("timeout_error_clears", 64'(error), 64'd0);

    // Partial word from the timed-out load must not leak into the next one
    e.addr = 9'd0; e.data = 32'h44332211; sb_q.push_back(e);
    do_start(1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_idle("after_timeout_idle", 20);
    check("after_timeout_checksum", 64'(checksum), 64'h44332211);

    // Reset after the second write of a four-word load
    e.addr = 9'd0; e.data = 32'h14131211; sb_q.push_back(e);
    e.addr = 9'd1; e.data = 32'h18171615; sb_q.push_back(e);
    do_start(4);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
    check("second_write_strobe", 64'(m_write), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs",
          64'({in_ready, m_address, m_writedata, m_chipselect, m_write, m_debugaccess,
               busy, done, error, checksum}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midreset_no_writes", 64'(wr_cnt - w0), 64'd0);
    check("midreset_idle", 64'({busy, in_ready}), 64'd0);
    check("midreset_sb_empty", 64'(sb_q.size()), 64'd0);

    // Start during a load is ignored
    e.addr = 9'd0; e.data = 32'hDDCCBBAA; sb_q.push_back(e);
    e.addr = 9'd1; e.data = 32'h01EFFE10; sb_q.push_back(e);
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    do_start(2);
    send_byte(8'hAA); send_byte(8'hBB);
    do_start(1);
    send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h10); send_byte(8'hFE); send_byte(8'hEF); send_byte(8'h01);
    wait_idle("restart_idle", 20);
    check("restart_writes", 64'(wr_cnt - w0), 64'd2);
    check("restart_checksum", 64'(checksum), 64'(32'hDDCCBBAA + 32'h01EFFE10));
    check("restart_done", 64'(done_cnt - d0), 64'd1);
    check("restart_no_error", 64'(err_cnt - e0), 64'd0);
    check("restart_sb_empty", 64'(sb_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule : tb_onchip_rom_loader

// File: doc/onchip_rom_loader.md
ONCHIP_ROM_LOADER -- requirements
Module: onchip_rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning word-address width of the target memory (depth 2^ADDR_W = 512).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning maximum idle cycles allowed between input bytes while loading.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port word_count  input  ADDR_W+1  number of 32-bit words to load, sampled on start.
REQ-007 SHALL have port in_data  input  8  boot-image byte.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port m_address  output  ADDR_W  memory word address.
REQ-011 SHALL have port m_writedata  output  32  memory write word.
REQ-012 SHALL have port m_byteenable  output  4  byte lanes.
REQ-013 SHALL have ports m_chipselect, m_write, m_debugaccess  output  1 each  memory write strobes.
REQ-014 SHALL have port m_clken  output  1  memory clock enable.
REQ-015 SHALL have ports busy, done, error  output  1 each  status; done and error are one-cycle pulses.
REQ-016 SHALL have port checksum  output  32  running sum of words written.

Function
REQ-017 SHALL implement states IDLE, COLLECT, WRITE, FINISH.
REQ-018 IDLE: start with word_count in 1..2^ADDR_W SHALL latch count, clear address, byte index and checksum, enter COLLECT next cycle.
REQ-019 IDLE: start with word_count 0 or > 2^ADDR_W SHALL pulse error next cycle and stay IDLE.
REQ-020 COLLECT: in_ready SHALL be 1; a byte transfers when in_valid & in_ready.
REQ-021 Bytes SHALL assemble little-endian: first byte of a word into bits [7:0], fourth into [31:24].
REQ-022 Transfer of the fourth byte SHALL move to WRITE; m_chipselect, m_write, m_debugaccess SHALL be 1 for exactly that next cycle with the assembled word and current address.
REQ-023 m_byteenable SHALL be 4'hF and m_clken SHALL be 1 at all times.
REQ-024 WRITE: in_ready SHALL be 0; checksum SHALL add the written word modulo 2^32; address SHALL increment; if words written equals count go FINISH, else COLLECT.
REQ-025 FINISH: done SHALL pulse for one cycle, then IDLE; checksum SHALL hold its final value until next accepted start.
REQ-026 busy SHALL be 1 in COLLECT, WRITE, FINISH; 0 in IDLE.
REQ-027 start while busy SHALL be ignored.
REQ-028 Idle counter SHALL count COLLECT cycles without transfer and clear on each transfer; reaching TIMEOUT SHALL pulse error, discard the partial word, return to IDLE; memory words already written remain.
REQ-029 Address SHALL never exceed 2^ADDR_W-1; a 512-word load ends at address 511 with no wrap.
REQ-030 Write strobes SHALL be 0 in every state except WRITE.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, in_ready 0, all m_* strobes 0, m_address 0, m_writedata 0, busy/done/error 0, checksum 0, counters 0.
REQ-032 Reset mid-load SHALL abandon the load with no further memory writes after deassertion.

Structure
REQ-033 State enumeration and the 4'hF byteenable constant SHALL live in a shared package onchip_rom_pkg.
REQ-034 Byte-to-word assembly (shift register plus byte index) SHALL be one sub-module, onchip_rom_word_packer.

Verification
REQ-035 word_count=2, bytes 01 02 03 04 05 06 07 08 back-to-back -> writes 32'h04030201 @0, 32'h08070605 @1, checksum 32'h0C0A0806, one done pulse.
REQ-036 word_count=0 start -> error pulse next cycle, no write strobe, busy stays 0.
REQ-037 word_count=512, bytes FF -> 512 writes of 32'hFFFFFFFF, last at address 511, checksum 32'hFFFFFE00.
REQ-038 word_count=1, two bytes then in_valid low for TIMEOUT cycles -> error pulse, IDLE, no write.
REQ-039 reset_n low after second write of a 4-word load -> all outputs 0 immediately, no writes after release.
REQ-040 start asserted during COLLECT -> ignored, load completes with original count.
